// File: rtl/turbo_interleaver.sv
// QPP turbo-code interleaver: buffers one K-bit frame in natural order, then drains it in permuted order.
// Optional macro TURBO_ILV_DEINT_EN adds an inv port that selects the inverse (deinterleaving) permutation.
module turbo_interleaver #(
    parameter int FRAME_LEN = 16,
    parameter int F1        = 3,
    parameter int F2        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic in_valid,
    input  logic in_bit,
`ifdef TURBO_ILV_DEINT_EN
    input  logic inv,
`endif
    output logic in_ready,
    output logic out_valid,
    output logic out_bit,
    output logic out_last,
    input  logic out_ready
);

    localparam int AW = $clog2(FRAME_LEN);

    localparam logic [AW-1:0] G_INIT = AW'((F1 + F2) % FRAME_LEN);
    localparam logic [AW-1:0] G_STEP = AW'((2 * F2) % FRAME_LEN);
    localparam logic [AW-1:0] LAST   = AW'(FRAME_LEN - 1);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]           state;
    logic [FRAME_LEN-1:0] mem;
    logic [AW-1:0]        wr_cnt;
    logic [AW-1:0]        rd_cnt;
    logic [AW-1:0]        pi;
    logic [AW-1:0]        g;

    logic          accept;
    logic          xfer;
    logic          wr_inv;
    logic          rd_inv;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign in_ready  = ena & (state == FILL);
    assign out_valid = ena & (state == DRAIN);
    assign out_last  = out_valid & (rd_cnt == LAST);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

`ifdef TURBO_ILV_DEINT_EN
    logic inv_r;

    // The first accept of a frame uses inv directly; later accepts and the drain use the sampled copy.
    assign wr_inv = (wr_cnt == '0) ? inv : inv_r;
    assign rd_inv = inv_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_r <= 1'b0;
        end else if (accept && wr_cnt == '0) begin
            inv_r <= inv;
        end
    end
`else
    assign wr_inv = 1'b0;
    assign rd_inv = 1'b0;
`endif

    assign wr_addr = wr_inv ? pi : wr_cnt;
    assign rd_addr = rd_inv ? rd_cnt : pi;
    assign out_bit = out_valid & mem[rd_addr];

    // NOTE: the frame buffer is a flop vector cleared by reset, so no stale bits survive an aborted frame;
    // all state uses non-blocking assignments so pi and g advance from their pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            mem    <= '0;
            wr_cnt <= '0;
            rd_cnt <= '0;
            pi     <= '0;
            g      <= G_INIT;
        end else if (ena) begin
            if (accept) begin
                mem[wr_addr] <= in_bit;
                if (wr_cnt == LAST) begin
                    state  <= DRAIN;
                    wr_cnt <= '0;
                    pi     <= '0;
                    g      <= G_INIT;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                    if (wr_inv) begin
                        pi <= pi + g;
                        g  <= g + G_STEP;
                    end
                end
            end
            if (xfer) begin
                if (out_last) begin
                    state  <= FILL;
                    rd_cnt <= '0;
                    pi     <= '0;
                    g      <= G_INIT;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (!rd_inv) begin
                        pi <= pi + g;
                        g  <= g + G_STEP;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_turbo_interleaver.sv
// Self-checking bench for turbo_interleaver: directed frames plus randomized frames against a QPP formula model.
module tb_turbo_interleaver;

    localparam int K  = 16;
    localparam int F1 = 3;
    localparam int F2 = 4;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic ena       = 1'b0;
    logic in_valid  = 1'b0;
    logic in_bit    = 1'b0;
    logic out_ready = 1'b0;
    logic inv       = 1'b0;
    logic in_ready, out_valid, out_bit, out_last;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    turbo_interleaver #(.FRAME_LEN(K), .F1(F1), .F2(F2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
`ifdef TURBO_ILV_DEINT_EN
        .inv       (inv),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    // Closed-form permutation, independent of the incremental recursion in the design.
    function automatic int pi_of(input int i);
        return (F1 * i + F2 * i * i) % K;
    endfunction

    function automatic logic [K-1:0] perm(input logic [K-1:0] s);
        logic [K-1:0] r;
        for (int i = 0; i < K; i++) r[i] = s[pi_of(i)];
        return r;
    endfunction

    function automatic logic [K-1:0] inv_perm(input logic [K-1:0] s);
        logic [K-1:0] r;
        for (int n = 0; n < K; n++) r[pi_of(n)] = s[n];
        return r;
    endfunction

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [K-1:0] bits, input bit rnd, input int gap_after, output int cycles);
        int n = 0;
        int gaps = 0;
        cycles = 0;
        while (n < K && cycles < 2000) begin
            in_bit = bits[n];
            in_valid = 1'b1;
            if (n == gap_after && gaps < 4) begin
                ena = 1'b0;
                #1;
                check(in_ready, 0, "gap_in_ready");
                check(out_valid, 0, "gap_out_valid");
                check(out_last, 0, "gap_out_last");
                gaps++;
            end else begin
                ena = 1'b1;
                if (rnd) in_valid = ($urandom_range(0, 3) != 0);
                #1;
                if (in_valid && in_ready) n++;
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        ena = 1'b1;
        check(n, K, "feed_accepts");
        #1;
        check(out_valid, 1, "first_out_valid");
        check(in_ready, 0, "drain_in_ready");
    endtask

    task automatic drain(input logic [K-1:0] exp, input bit rnd, input int stall_pos, input int abort_at,
                         output logic [K-1:0] got, output int cycles, output int busy);
        int i = 0;
        int stalls = 0;
        cycles = 0;
        busy = 0;
        got = '0;
        while (i < K && cycles < 2000) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check(out_valid, 0, "abort_out_valid");
                check(out_bit, 0, "abort_out_bit");
                check(out_last, 0, "abort_out_last");
                tick();
                rst_n = 1'b1;
                #1;
                check(in_ready, 1, "abort_in_ready");
                check(out_valid, 0, "abort_no_residual");
                out_ready = 1'b0;
                return;
            end
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            else if (i == stall_pos && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else out_ready = 1'b1;
            #1;
            if (!in_ready) busy++;
            check(out_valid, 1, "out_valid");
            check(out_bit, exp[i], $sformatf("out_bit[%0d]", i));
            check(out_last, (i == K - 1), $sformatf("out_last[%0d]", i));
            got[i] = out_bit;
            if (out_ready) i++;
            tick();
            cycles++;
        end
        out_ready = 1'b0;
        check(i, K, "drain_transfers");
        #1;
        check(in_ready, 1, "ready_after_frame");
        check(out_valid, 0, "idle_after_frame");
    endtask

    initial begin
        logic [K-1:0] src, got, got2;
        int fc, dc, busy, total;

        // Reset state
        rst_n = 1'b0;
        ena = 1'b1;
        #1;
        check(out_valid, 0, "rst_out_valid");
        check(out_bit, 0, "rst_out_bit");
        check(out_last, 0, "rst_out_last");
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check(in_ready, 1, "rst_in_ready");

        // Single one at input bit 7 lands on output position 1
        src = 16'h0080;
        feed(src, 1'b0, -1, fc);
        check(fc, K, "single7_fill_cycles");
        drain(perm(src), 1'b0, -1, -1, got, dc, busy);
        check(got, 16'h0002, "single7_pattern");
        check(dc, K, "single7_drain_cycles");

        // Single one at input bit 1, stall three cycles on the last output
        src = 16'h0002;
        feed(src, 1'b0, -1, fc);
        drain(perm(src), 1'b0, K - 1, -1, got, dc, busy);
        check(got, 16'h8000, "single1_pattern");
        check(dc, K + 3, "single1_drain_cycles");

        // Alternating bits with a four-cycle enable gap after five accepts
        src = 16'h5555;
        feed(src, 1'b0, 5, fc);
        check(fc, K + 4, "gap_fill_cycles");
        drain(perm(src), 1'b0, -1, -1, got, dc, busy);

        // Reset at output position 6, then a fresh frame
        src = 16'($urandom);
        feed(src, 1'b0, -1, fc);
        drain(perm(src), 1'b0, -1, 6, got, dc, busy);
        src = 16'($urandom);
        feed(src, 1'b0, -1, fc);
        drain(perm(src), 1'b0, -1, -1, got, dc, busy);

        // Two back-to-back frames with both sides always ready
        total = 0;
        for (int f = 0; f < 2; f++) begin
            src = 16'($urandom);
            feed(src, 1'b0, -1, fc);
            drain(perm(src), 1'b0, -1, -1, got, dc, busy);
            check(busy, K, "b2b_in_ready_low");
            total += fc + dc;
        end
        check(total, 4 * K, "b2b_total_cycles");

        // Random frames with random input gaps and output stalls
        for (int f = 0; f < 4; f++) begin
            src = 16'($urandom);
            feed(src, 1'b1, -1, fc);
            drain(perm(src), 1'b1, -1, -1, got, dc, busy);
        end

`ifdef TURBO_ILV_DEINT_EN
        // Interleave then deinterleave recovers the original frame
        src = 16'($urandom);
        inv = 1'b0;
        feed(src, 1'b0, -1, fc);
        drain(perm(src), 1'b0, -1, -1, got, dc, busy);
        inv = 1'b1;
        feed(got, 1'b1, -1, fc);
        inv = 1'b0;
        drain(inv_perm(got), 1'b1, -1, -1, got2, dc, busy);
        check(got2, src, "deint_roundtrip");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/turbo_interleaver.md
TURBO_INTERLEAVER -- requirements
Module: turbo_interleaver

Interface
REQ-001 Parameter FRAME_LEN, default 16; frame length K in bits; power of two, 8..64.
REQ-002 Parameter F1, default 3; QPP linear coefficient; odd.
REQ-003 Parameter F2, default 4; QPP quadratic coefficient; even.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  design enable; low freezes all state.
REQ-007 in_valid  input  1  upstream bit valid.
REQ-008 in_bit  input  1  upstream systematic bit, natural order.
REQ-009 in_ready  output  1  block can accept a bit this cycle.
REQ-010 out_valid  output  1  out_bit valid for the downstream second RSC encoder.
REQ-011 out_bit  output  1  permuted bit.
REQ-012 out_last  output  1  high with the final bit of a frame.
REQ-013 out_ready  input  1  downstream accepts out_bit this cycle.

Function
REQ-014 Two states, FILL and DRAIN; K-entry bit memory; write counter wr_cnt and read counter rd_cnt, each log2(K) bits.
REQ-015 FILL: in_ready = ena; out_valid = 0; an accept (in_valid & in_ready) writes in_bit to mem[wr_cnt], then increments wr_cnt.
REQ-016 The K-th accept moves the block to DRAIN on the same edge; the first out_valid is the following cycle (latency 1 cycle after the last input).
REQ-017 DRAIN: in_ready = 0; out_valid = ena; out_bit = mem[pi], where pi is the current permuted address register.
REQ-018 Address recursion, all mod K: pi starts at 0 and g at (F1+F2); on each output transfer (out_valid & out_ready), pi <= pi+g, g <= g+2*F2, rd_cnt++. This equals pi(i) = (F1*i + F2*i*i) mod K.
REQ-019 out_last = out_valid when rd_cnt = K-1.
REQ-020 The transfer with out_last returns the block to FILL, clears wr_cnt, rd_cnt and pi, and reloads g.
REQ-021 With out_valid high and out_ready low, out_bit, out_last and all counters hold.
REQ-022 ena low: in_ready = 0, out_valid = 0, out_last = 0; no state changes; on re-enable, operation resumes at the same position.
REQ-023 A continuous handshake on both sides gives exactly 2*K cycles per frame.
REQ-024 Memory is not read-modified during DRAIN. Input bits presented during DRAIN are not accepted.

Reset
REQ-025 While rst_n is low: state = FILL, wr_cnt = rd_cnt = pi = 0, g = (F1+F2) mod K, memory = 0, out_valid = 0, out_bit = 0, out_last = 0.
REQ-026 in_ready = ena from the first cycle after rst_n deasserts.
REQ-027 Reset in mid-FILL or mid-DRAIN discards the partial frame; no residual output appears.

Configuration
REQ-028 Macro TURBO_ILV_DEINT_EN: when defined, the block adds input port inv (1 bit), sampled on the first accept of each frame.
REQ-029 With the macro defined and inv=1 for a frame: writes go to mem[pi] (pi advances per input accept), and reads are sequential mem[rd_cnt]. This is the inverse permutation for the decoder.
REQ-030 With the macro defined and inv=0, or with the macro undefined (no inv port), the block behaves exactly as REQ-015..REQ-021.

Verification (K=16, F1=3, F2=4; output order pi = 0,7,6,13,12,3,2,9,8,15,14,5,4,11,10,1)
REQ-031 Input frame with only bit 7 = 1, out_ready held 1 -> out_bit = 1 only at output position 1; out_last at position 15; first out_valid 1 cycle after the 16th accept.
REQ-032 Input frame with only bit 1 = 1, out_ready low for 3 cycles at position 15 -> out_bit=1 and out_last=1 held stable for those 3 cycles, then one transfer, then in_ready=1.
REQ-033 in_valid held 1 with alternating bits, ena pulled low for 4 cycles after 5 accepts -> no accepts during the gap, frame completes with 16 accepts, and the output matches the permuted order.
REQ-034 rst_n asserted at output position 6 -> out_valid=0 immediately; after release in_ready=1 and a new frame drains correctly.
REQ-035 Two back-to-back frames, both sides always ready -> 64 cycles, 32 transfers, in_ready=0 for 16 cycles per DRAIN.
REQ-036 With TURBO_ILV_DEINT_EN defined: frame through inv=0, its output fed back with inv=1 -> recovered bits equal the original 16 bits.
